// File: rtl/cam_pixel_capture_if.sv
// Camera capture bus: OV7670-style sensor inputs plus frame-buffer write side.
// slave  = the capture block, master = whatever drives the sensor pins and
// consumes the frame-buffer writes.
interface cam_pixel_capture_if #(
  parameter int ADDR_WIDTH = 19
);
  logic                  start;
  logic                  pclk;
  logic                  vsync;
  logic                  href;
  logic [7:0]            data;
  logic                  we;
  logic [ADDR_WIDTH-1:0] address;
  logic [7:0]            pixel;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] pixel_count;
  logic                  line_err;

  modport slave (
    input  start, pclk, vsync, href, data,
    output we, address, pixel, busy, done, pixel_count, line_err
  );

  modport master (
    output start, pclk, vsync, href, data,
    input  we, address, pixel, busy, done, pixel_count, line_err
  );
endinterface

// File: rtl/cam_pixel_capture.sv
// Camera pixel capture: samples an asynchronous OV7670-style parallel bus in
// the clk domain, packs RGB565 byte pairs into RGB332 pixels and emits
// single-cycle frame-buffer writes for one frame per start request.
// Optional build macro CAM_PIXEL_CAPTURE_TEST_PATTERN_EN: the written pixel is
// address[7:0] instead of sensor data (timing still follows pclk/href/vsync).
// ADDR_WIDTH must match the interface instance and be at least 8.
module cam_pixel_capture #(
  parameter int ADDR_WIDTH  = 19,
  parameter int MAX_PIXELS  = 19200,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  cam_pixel_capture_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(MAX_PIXELS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_pclk_sync;
  logic [SYNC_STAGES-1:0]  r_vsync_sync;
  logic [SYNC_STAGES-1:0]  r_href_sync;
  logic [7:0]              r_data_pipe [SYNC_STAGES];
  logic                    r_pclk_prev;
  logic                    r_vsync_prev;
  logic                    r_href_prev;
  logic                    r_phase;
  logic [5:0]              r_hi;
  logic [ADDR_WIDTH-1:0]   r_counter;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [ADDR_WIDTH-1:0]   r_pixel_count;
  logic [7:0]              r_pixel;
  logic                    r_we;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_line_err;

  logic                    w_pclk_s;
  logic                    w_vsync_s;
  logic                    w_href_s;
  logic [7:0]              w_data_s;
  logic                    w_tick;
  logic                    w_vsync_rise;
  logic                    w_vsync_fall;
  logic                    w_href_fall;
  logic                    w_not_full;
  logic                    w_write;
  logic [ADDR_WIDTH-1:0]   w_count_inc;
  logic [7:0]              w_pixel_next;

  assign w_pclk_s     = r_pclk_sync[SYNC_STAGES-1];
  assign w_vsync_s    = r_vsync_sync[SYNC_STAGES-1];
  assign w_href_s     = r_href_sync[SYNC_STAGES-1];
  assign w_data_s     = r_data_pipe[SYNC_STAGES-1];
  assign w_tick       = w_pclk_s & ~r_pclk_prev;
  assign w_vsync_rise = w_vsync_s & ~r_vsync_prev;
  assign w_vsync_fall = ~w_vsync_s & r_vsync_prev;
  assign w_href_fall  = ~w_href_s & r_href_prev;
  assign w_not_full   = (r_counter < MAX_CNT);
  assign w_count_inc  = r_counter + ADDR_WIDTH'(1);
  // A pixel write happens on the second-byte tick, unless the buffer is full.
  assign w_write      = (r_state == CAPTURE) & w_tick & w_href_s & r_phase & w_not_full;

`ifdef CAM_PIXEL_CAPTURE_TEST_PATTERN_EN
  assign w_pixel_next = r_counter[7:0];
`else
  // RGB565 -> RGB332: R[4:2] from hi[7:5], G[5:3] from hi[2:0], B[4:3] from lo[4:3].
  assign w_pixel_next = {r_hi, w_data_s[4:3]};
`endif

  // Synchronize the camera control lines and keep their previous values for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pclk_sync  <= '0;
      r_vsync_sync <= '0;
      r_href_sync  <= '0;
      r_pclk_prev  <= 1'b0;
      r_vsync_prev <= 1'b0;
      r_href_prev  <= 1'b0;
    end else begin
      r_pclk_sync  <= {r_pclk_sync[SYNC_STAGES-2:0], bus.pclk};
      r_vsync_sync <= {r_vsync_sync[SYNC_STAGES-2:0], bus.vsync};
      r_href_sync  <= {r_href_sync[SYNC_STAGES-2:0], bus.href};
      r_pclk_prev  <= w_pclk_s;
      r_vsync_prev <= w_vsync_s;
      r_href_prev  <= w_href_s;
    end
  end

  // Data delay line of the same depth, so a sample tick sees the byte that
  // was on the bus when pclk rose.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_data_pipe
      if (gi == 0) begin : g_first
        // First data stage takes the raw camera byte.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) r_data_pipe[gi] <= 8'h00;
          else      r_data_pipe[gi] <= bus.data;
        end
      end else begin : g_next
        // Later data stages shift the byte along.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) r_data_pipe[gi] <= 8'h00;
          else      r_data_pipe[gi] <= r_data_pipe[gi-1];
        end
      end
    end
  endgenerate

  // Capture FSM: arm on start, begin at a vsync fall, pack pixels, end at a vsync rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_phase       <= 1'b0;
      r_hi          <= 6'd0;
      r_counter     <= '0;
      r_address     <= '0;
      r_pixel_count <= '0;
      r_pixel       <= 8'h00;
      r_we          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_line_err    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state       <= ARM;
            r_counter     <= '0;
            r_address     <= '0;
            r_pixel_count <= '0;
            r_line_err    <= 1'b0;
            r_phase       <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        ARM: begin
          // Only a falling vsync marks the start of a complete frame.
          if (w_vsync_fall) begin
            r_state <= CAPTURE;
            r_phase <= 1'b0;
          end
        end
        CAPTURE: begin
          if (w_tick && w_href_s) begin
            if (!r_phase) begin
              r_hi    <= {w_data_s[7:5], w_data_s[2:0]};
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (w_not_full) begin
                r_we      <= 1'b1;
                r_address <= r_counter;
                r_pixel   <= w_pixel_next;
                r_counter <= w_count_inc;
              end
            end
          end else if (w_href_fall && r_phase) begin
            // A line ended halfway through a pixel: flag it and resync the byte phase.
            r_line_err <= 1'b1;
            r_phase    <= 1'b0;
          end
          if (w_vsync_rise) begin
            // Frame end; a pixel completed on this same tick is still counted.
            r_state       <= IDLE;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_phase       <= 1'b0;
            r_pixel_count <= w_write ? w_count_inc : r_counter;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.we          = r_we;
  assign bus.address     = r_address;
  assign bus.pixel       = r_pixel;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pixel_count = r_pixel_count;
  assign bus.line_err    = r_line_err;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture: stimulus pushes expected writes and
// frame-end counts, a negedge monitor pops and compares them as the DUT emits.
module tb_cam_pixel_capture;
  localparam int AW   = 19;
  localparam int MAXP = 6;

  logic clk;
  logic rst;

  cam_pixel_capture_if #(.ADDR_WIDTH(AW)) bus ();

  cam_pixel_capture #(
    .ADDR_WIDTH(AW),
    .MAX_PIXELS(MAXP),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int addr_q[$];
  logic [7:0] px_q[$];
  int done_q[$];
  logic prev_busy = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [7:0] exp_pixel(input logic [7:0] hand, input int addr);
`ifdef CAM_PIXEL_CAPTURE_TEST_PATTERN_EN
    logic [31:0] a;
    a = addr;
    return a[7:0];
`else
    return hand;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    bus.data = b;
    tick(4);
    bus.pclk = 1'b1;
    tick(4);
    bus.pclk = 1'b0;
  endtask

  // Expected write is queued only while the modelled buffer has room.
  task automatic push_px(input logic [7:0] hand);
    if (exp_cnt < MAXP) begin
      addr_q.push_back(exp_cnt);
      px_q.push_back(exp_pixel(hand, exp_cnt));
      exp_cnt++;
    end
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] hand);
    cam_byte(hi);
    push_px(hand);
    cam_byte(lo);
  endtask

  task automatic pulse_start();
    tick(1);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic vsync_pulse();
    bus.vsync = 1'b1;
    tick(12);
    bus.vsync = 1'b0;
    tick(12);
  endtask

  task automatic frame_end(input int cnt);
    done_q.push_back(cnt);
    bus.vsync = 1'b1;
    tick(12);
  endtask

  task automatic href_on();
    bus.href = 1'b1;
    tick(2);
  endtask

  task automatic href_off();
    bus.href = 1'b0;
    tick(8);
  endtask

  // Monitor: every write strobe and every done pulse is matched against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.we) begin
        if (addr_q.size() == 0) begin
          check("unexpected_we_addr", bus.address, 'hFFFFF);
        end else begin
          check("we_address", bus.address, addr_q.pop_front());
          check("we_pixel", bus.pixel, px_q.pop_front());
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", bus.pixel_count, 'hFFFFF);
        end else begin
          check("done_pixel_count", bus.pixel_count, done_q.pop_front());
          check("done_busy_low", bus.busy, 0);
          check("busy_before_done", prev_busy, 1);
        end
      end
    end
    prev_busy = bus.busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.pclk  = 1'b0;
    bus.vsync = 1'b0;
    bus.href  = 1'b0;
    bus.data  = 8'h00;
    tick(5);
    check("rst_we", bus.we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b1;
    tick(10);
    check("idle_address", bus.address, 0);
    check("idle_pixel", bus.pixel, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_pixel_count", bus.pixel_count, 0);
    check("idle_line_err", bus.line_err, 0);

    // Basic frame: two pixels F8,00 -> E0 and 07,E0 -> 1C.
    exp_cnt = 0;
    pulse_start();
    check("busy_after_start", bus.busy, 1);
    vsync_pulse();
    href_on();
    send_pixel(8'hF8, 8'h00, 8'hE0);
    send_pixel(8'h07, 8'hE0, 8'h1C);
    href_off();
    frame_end(2);
    check("frame1_busy", bus.busy, 0);
    check("frame1_pixel_count", bus.pixel_count, 2);

    // Odd byte line, then a clean line starting from phase 0.
    exp_cnt = 0;
    pulse_start();
    vsync_pulse();
    href_on();
    send_pixel(8'hA5, 8'h5A, 8'hB7);
    cam_byte(8'h12);
    href_off();
    check("odd_line_err", bus.line_err, 1);
    href_on();
    send_pixel(8'h12, 8'h34, 8'h0A);
    href_off();
    frame_end(2);
    check("line_err_held", bus.line_err, 1);

    // Start while vsync already low mid-frame: nothing until a full vsync cycle.
    bus.vsync = 1'b0;
    tick(12);
    exp_cnt = 0;
    pulse_start();
    check("start_clears_line_err", bus.line_err, 0);
    href_on();
    cam_byte(8'hC8);
    cam_byte(8'h18);
    href_off();
    pulse_start();
    check("busy_second_start", bus.busy, 1);
    vsync_pulse();
    href_on();
    send_pixel(8'hC8, 8'h18, 8'hC3);
    send_pixel(8'hFF, 8'hFF, 8'hFF);
    href_off();
    frame_end(2);

    // Overfull frame: MAXP+5 pixels, only MAXP written.
    exp_cnt = 0;
    pulse_start();
    vsync_pulse();
    href_on();
    for (int i = 0; i < MAXP + 5; i++) begin
      if (i % 2 == 0) send_pixel(8'hF8, 8'h00, 8'hE0);
      else            send_pixel(8'h07, 8'hE0, 8'h1C);
    end
    href_off();
    frame_end(MAXP);
    check("full_pixel_count", bus.pixel_count, MAXP);

    // Reset in the middle of a line during capture.
    exp_cnt = 0;
    pulse_start();
    vsync_pulse();
    href_on();
    send_pixel(8'hF8, 8'h00, 8'hE0);
    cam_byte(8'h07);
    bus.data = 8'hE0;
    tick(2);
    rst = 1'b0;
    #1;
    check("midrst_we", bus.we, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_address", bus.address, 0);
    tick(3);
    bus.href = 1'b0;
    rst = 1'b1;
    tick(4);
    check("midrst_pixel_count", bus.pixel_count, 0);
    exp_cnt = 0;
    pulse_start();
    vsync_pulse();
    href_on();
    send_pixel(8'h07, 8'hE0, 8'h1C);
    href_off();
    frame_end(1);

    // vsync rise on the same tick as a second byte: pixel written and counted.
    exp_cnt = 0;
    pulse_start();
    vsync_pulse();
    href_on();
    cam_byte(8'h12);
    bus.data = 8'h34;
    push_px(8'h0A);
    done_q.push_back(1);
    tick(4);
    bus.pclk  = 1'b1;
    bus.vsync = 1'b1;
    tick(4);
    bus.pclk = 1'b0;
    bus.href = 1'b0;
    tick(10);
    check("simul_pixel_count", bus.pixel_count, 1);
    check("simul_line_err", bus.line_err, 0);

    tick(20);
    check("pending_writes", addr_q.size(), 0);
    check("pending_done", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
